// File: rtl/pc_status_unit.sv
// Next-PC and status-flag stage: holds PC and {Z,N,V}, resolves branches/jumps,
// drives the link write, counts taken transfers and flags misaligned register/memory targets.
module pc_status_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             blezalsig,
  input  logic             balvsig,
  input  logic             brvsig,
  input  logic             jmxorsig,
  input  logic             jalpcsig,
  input  logic             status_write_sig,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      link_data,
  output logic             link_en,
  output logic             link_ra,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             align_err
);

  logic [31:0] pc_reg;
  logic [2:0]  status_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic        align_reg;

  logic [31:0] bta;
  logic [31:0] jta;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;

  logic        taken;
  logic [31:0] target;
  logic        link_sel;
  logic        ra_sel;
  logic        chk_align;
  logic        misalign;
  logic        redirect;
  logic [31:0] pc_next;

  assign pc_plus4 = pc_reg + 32'd4;
  assign bta      = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jta      = {pc_plus4[31:28], target26, 2'b00};
  assign flag_z   = status_reg[2];
  assign flag_n   = status_reg[1];
  assign flag_v   = status_reg[0];

  // Strobe priority resolves illegal multi-strobe cycles; decisions use the pre-edge status.
  always_comb begin
    taken     = 1'b0;
    target    = pc_plus4;
    link_sel  = 1'b0;
    ra_sel    = 1'b0;
    chk_align = 1'b0;
    if (jmxorsig) begin
      taken     = 1'b1;
      target    = mem_rdata;
      link_sel  = 1'b1;
      chk_align = 1'b1;
    end else if (brvsig) begin
      taken     = flag_v;
      target    = rs_data;
      link_sel  = 1'b1;
      chk_align = 1'b1;
    end else if (balvsig) begin
      taken    = flag_v;
      target   = jta;
      link_sel = 1'b1;
      ra_sel   = 1'b1;
    end else if (blezalsig) begin
      taken    = flag_z | flag_n;
      target   = bta;
      link_sel = 1'b1;
      ra_sel   = 1'b1;
    end else if (jalpcsig) begin
      taken    = 1'b1;
      target   = bta;
      link_sel = 1'b1;
      ra_sel   = 1'b1;
    end else if (branch) begin
      taken  = alu_zero;
      target = bta;
    end
  end

  assign misalign = taken & chk_align & (target[1:0] != 2'b00);
  assign redirect = taken & ~misalign;
  assign pc_next  = redirect ? target : pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      status_reg <= 3'b000;
      cnt_reg    <= '0;
      align_reg  <= 1'b0;
    end else if (!stall) begin
      pc_reg <= pc_next;
      if (status_write_sig)
        status_reg <= {alu_zero, alu_neg, alu_ovf};
      if (redirect && !(&cnt_reg))
        cnt_reg <= cnt_reg + 1'b1;
      if (misalign)
        align_reg <= 1'b1;
    end
  end

  assign pc        = pc_reg;
  assign status    = status_reg;
  assign taken_cnt = cnt_reg;
  assign align_err = align_reg;
  assign link_data = pc_plus4;
  assign link_en   = link_sel & ~stall;
  assign link_ra   = ra_sel;

endmodule

// File: tb/tb_pc_status_unit.sv
// Directed bench for pc_status_unit (CNT_W=2 so counter saturation is reachable).
module tb_pc_status_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, blezalsig, balvsig, brvsig, jmxorsig, jalpcsig;
  logic        status_write_sig, alu_zero, alu_neg, alu_ovf;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_data, mem_rdata;
  logic [31:0] pc, pc_plus4, link_data;
  logic        link_en, link_ra, align_err;
  logic [2:0]  status;
  logic [1:0]  taken_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_status_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .blezalsig(blezalsig), .balvsig(balvsig), .brvsig(brvsig),
    .jmxorsig(jmxorsig), .jalpcsig(jalpcsig),
    .status_write_sig(status_write_sig), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_ovf(alu_ovf), .imm16(imm16),
    .target26(target26), .rs_data(rs_data), .mem_rdata(mem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .link_data(link_data),
    .link_en(link_en), .link_ra(link_ra), .status(status),
    .taken_cnt(taken_cnt), .align_err(align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stall = 0; branch = 0; blezalsig = 0; balvsig = 0; brvsig = 0;
    jmxorsig = 0; jalpcsig = 0; status_write_sig = 0;
    alu_zero = 0; alu_neg = 0; alu_ovf = 0;
    imm16 = '0; target26 = '0; rs_data = '0; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%h status=%b cnt=%0d align=%b", $time, pc, status, taken_cnt, align_err);
  endtask

  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_status", {29'd0, status}, 32'h0);
    chk("rst_cnt", {30'd0, taken_cnt}, 32'h0);
    chk("rst_align", {31'd0, align_err}, 32'h0);
    @(negedge clk) reset = 0;

    // Run to 0x3C, then a taken beq with a status write lands on 0x40.
    repeat (15) tick();
    chk("seq_pc", pc, 32'h3C);
    branch = 1; alu_zero = 1; status_write_sig = 1; alu_neg = 1; alu_ovf = 1;
    tick();
    clr();
    chk("beq_pc", pc, 32'h40);
    chk("beq_status", {29'd0, status}, 32'h7);
    chk("beq_cnt", {30'd0, taken_cnt}, 32'h1);
    // Asynchronous reset mid-cycle takes effect before the next edge.
    #2 reset = 1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_status", {29'd0, status}, 32'h0);
    chk("arst_cnt", {30'd0, taken_cnt}, 32'h0);
    @(negedge clk) reset = 0;

    // balv after V set; target26=0x10 -> 0x40.
    status_write_sig = 1; alu_ovf = 1;
    tick();
    clr();
    chk("sw_status", {29'd0, status}, 32'h1);
    chk("sw_pc", pc, 32'h4);
    balvsig = 1; target26 = 26'h10;
    #1;
    chk("balv_link_en", {31'd0, link_en}, 32'h1);
    chk("balv_link_ra", {31'd0, link_ra}, 32'h1);
    chk("balv_link_data", link_data, 32'h8);
    tick();
    clr();
    chk("balv_pc", pc, 32'h40);
    chk("balv_cnt", {30'd0, taken_cnt}, 32'h1);

    // blezal with Z=1, offset -4 -> branch to self.
    status_write_sig = 1; alu_zero = 1;
    tick();
    clr();
    chk("z_status", {29'd0, status}, 32'h4);
    blezalsig = 1; imm16 = 16'hFFFF;
    #1;
    chk("blezal_link_en", {31'd0, link_en}, 32'h1);
    chk("blezal_link_data", link_data, 32'h48);
    tick();
    clr();
    chk("blezal_pc", pc, 32'h44);
    chk("blezal_cnt", {30'd0, taken_cnt}, 32'h2);
    status_write_sig = 1;
    tick();
    clr();
    chk("clr_pc", pc, 32'h48);
    blezalsig = 1; imm16 = 16'hFFFF;
    #1;
    chk("blezal_nt_link_en", {31'd0, link_en}, 32'h1);
    tick();
    clr();
    chk("blezal_nt_pc", pc, 32'h4C);
    chk("blezal_nt_cnt", {30'd0, taken_cnt}, 32'h2);

    // brv misaligned then aligned.
    status_write_sig = 1; alu_ovf = 1;
    tick();
    clr();
    chk("v_pc", pc, 32'h50);
    brvsig = 1; rs_data = 32'h103;
    #1;
    chk("brv_link_en", {31'd0, link_en}, 32'h1);
    chk("brv_link_ra", {31'd0, link_ra}, 32'h0);
    tick();
    clr();
    chk("brv_mis_pc", pc, 32'h54);
    chk("brv_mis_align", {31'd0, align_err}, 32'h1);
    chk("brv_mis_cnt", {30'd0, taken_cnt}, 32'h2);
    tick();
    chk("align_sticky", {31'd0, align_err}, 32'h1);
    brvsig = 1; rs_data = 32'h100;
    tick();
    clr();
    chk("brv_pc", pc, 32'h100);
    chk("brv_cnt", {30'd0, taken_cnt}, 32'h3);

    // jmxor beats beq; counter already saturated.
    jmxorsig = 1; branch = 1; alu_zero = 1; imm16 = 16'h10; mem_rdata = 32'h200;
    #1;
    chk("jmxor_link_ra", {31'd0, link_ra}, 32'h0);
    chk("jmxor_link_en", {31'd0, link_en}, 32'h1);
    chk("jmxor_link_data", link_data, 32'h104);
    tick();
    clr();
    chk("jmxor_pc", pc, 32'h200);
    chk("sat_cnt", {30'd0, taken_cnt}, 32'h3);

    // Stall freezes everything and suppresses the link write.
    stall = 1; jalpcsig = 1; imm16 = 16'h4; status_write_sig = 1; alu_zero = 1;
    #1;
    chk("stall_link_en", {31'd0, link_en}, 32'h0);
    tick();
    clr();
    chk("stall_pc", pc, 32'h200);
    chk("stall_status", {29'd0, status}, 32'h1);
    chk("stall_cnt", {30'd0, taken_cnt}, 32'h3);
    jalpcsig = 1; imm16 = 16'h4;
    #1;
    chk("jalpc_link_en", {31'd0, link_en}, 32'h1);
    chk("jalpc_link_ra", {31'd0, link_ra}, 32'h1);
    tick();
    clr();
    chk("jalpc_pc", pc, 32'h214);
    chk("jalpc_sat_cnt", {30'd0, taken_cnt}, 32'h3);

    // PC wrap: brv to 0xFFFFFFFC, then sequential step to 0.
    brvsig = 1; rs_data = 32'hFFFF_FFFC;
    tick();
    clr();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    tick();
    chk("wrap_next", pc, 32'h0);

    // Fresh reset clears sticky error; misaligned jmxor sets it without counting.
    reset = 1;
    #1;
    chk("rst2_align", {31'd0, align_err}, 32'h0);
    @(negedge clk) reset = 0;
    jmxorsig = 1; mem_rdata = 32'h2;
    tick();
    clr();
    chk("jmxor_mis_pc", pc, 32'h4);
    chk("jmxor_mis_align", {31'd0, align_err}, 32'h1);
    chk("jmxor_mis_cnt", {30'd0, taken_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
